// File: rtl/input_conditioner.sv
// -----------------------------------------------------------------------------
// input_conditioner
//
// Purpose: conditions the raw board switches and buttons for the rest of the
// design. Every raw input goes through a two-flop synchronizer, is debounced
// against a common sample tick, and is then turned into:
//   - debounced levels for switches and buttons,
//   - a one-cycle press strobe per button (release gives no strobe),
//   - a serialized stream of switch rise ("up") and fall ("down") events.
//
// Event outputs are single-cycle valid strobes with no back-pressure. When
// up_valid is 1, up_idx names the switch that rose; when up_valid is 0,
// up_idx is 0. The down pair behaves the same way for falling switches and
// is independent of the up pair, so both may be valid in one cycle. Several
// pending events are emitted lowest index first, one per cycle.
//
// Parameters:
//   CLK_DIV    - CLK cycles per sample tick (2 .. 2**20)
//   DB_SAMPLES - consecutive differing ticks needed to accept a level (1..15)
//
// Build option:
//   INPUT_COND_FAST_SIM_EN - when defined, the tick period is 4 cycles
//                            regardless of CLK_DIV (for short simulations).
//
// Ports:
//   CLK        in   single clock, rising edge
//   RESET      in   synchronous, active-high reset
//   SW[9:0]    in   raw asynchronous switch levels
//   BTN[2:0]   in   raw asynchronous buttons: [0] ADMIN, [1] OK, [2] BACKSPACE
//   ms_tick    out  one-cycle sample-tick strobe
//   sw_level   out  debounced switch levels
//   btn_level  out  debounced button levels
//   btn_pulse  out  one-cycle strobe on each debounced button press
//   up_valid   out  a switch 0->1 event is presented this cycle
//   up_idx     out  index of that switch
//   down_valid out  a switch 1->0 event is presented this cycle
//   down_idx   out  index of that switch
// -----------------------------------------------------------------------------
module input_conditioner #(
    parameter int CLK_DIV    = 100000,
    parameter int DB_SAMPLES = 4
) (
    input  logic       CLK,
    input  logic       RESET,
    input  logic [9:0] SW,
    input  logic [2:0] BTN,
    output logic       ms_tick,
    output logic [9:0] sw_level,
    output logic [2:0] btn_level,
    output logic [2:0] btn_pulse,
    output logic       up_valid,
    output logic [3:0] up_idx,
    output logic       down_valid,
    output logic [3:0] down_idx
);

`ifdef INPUT_COND_FAST_SIM_EN
    localparam int TICK_P = 4;
`else
    localparam int TICK_P = CLK_DIV;
`endif

    localparam int          PW      = (TICK_P > 2) ? $clog2(TICK_P) : 1;
    localparam logic [PW-1:0] PRE_LAST = PW'(TICK_P - 1);
    localparam logic [3:0]  DB_N    = 4'(DB_SAMPLES);
    localparam int          N_IN    = 13;   // 10 switches + 3 buttons

    // Inputs are handled as one vector: [9:0] switches, [12:10] buttons.
    logic [N_IN-1:0]       in_meta_q, in_meta_d;
    logic [N_IN-1:0]       in_sync_q, in_sync_d;
    logic [PW-1:0]         pre_cnt_q, pre_cnt_d;
    logic [N_IN-1:0][3:0]  db_cnt_q,  db_cnt_d;
    logic [N_IN-1:0]       level_q,   level_d;
    logic [2:0]            btn_pulse_q, btn_pulse_d;
    logic [9:0]            pend_up_q, pend_up_d;
    logic [9:0]            pend_dn_q, pend_dn_d;
    logic                  up_valid_q, up_valid_d;
    logic [3:0]            up_idx_q,   up_idx_d;
    logic                  down_valid_q, down_valid_d;
    logic [3:0]            down_idx_q,   down_idx_d;

    logic       tick;
    logic [9:0] sw_rise, sw_fall;
    logic [9:0] up_clr, dn_clr;

    always_comb begin
        in_meta_d = {BTN, SW};
        in_sync_d = in_meta_q;

        // Prescaler: the tick is the last count of each period.
        tick      = (pre_cnt_q == PRE_LAST);
        pre_cnt_d = tick ? '0 : pre_cnt_q + PW'(1);

        // Debounce: count consecutive ticks where the synchronized input
        // disagrees with the accepted level; a single agreeing tick restarts
        // the count, so short glitches never reach the level.
        db_cnt_d = db_cnt_q;
        level_d  = level_q;
        if (tick) begin
            for (int i = 0; i < N_IN; i++) begin
                if (in_sync_q[i] != level_q[i]) begin
                    if (db_cnt_q[i] + 4'd1 == DB_N) begin
                        level_d[i]  = ~level_q[i];
                        db_cnt_d[i] = 4'd0;
                    end else begin
                        db_cnt_d[i] = db_cnt_q[i] + 4'd1;
                    end
                end else begin
                    db_cnt_d[i] = 4'd0;
                end
            end
        end

        // Pulse registers alongside the level so it is high in exactly the
        // first cycle the new level is visible.
        btn_pulse_d = level_d[12:10] & ~level_q[12:10];

        sw_rise = level_d[9:0] & ~level_q[9:0];
        sw_fall = level_q[9:0] & ~level_d[9:0];

        // Lowest-index pick: scanning downward lets the lowest set bit win.
        up_valid_d = 1'b0;
        up_idx_d   = 4'd0;
        up_clr     = 10'd0;
        for (int i = 9; i >= 0; i--) begin
            if (pend_up_q[i]) begin
                up_valid_d = 1'b1;
                up_idx_d   = 4'(i);
                up_clr     = 10'd1 << i;
            end
        end

        down_valid_d = 1'b0;
        down_idx_d   = 4'd0;
        dn_clr       = 10'd0;
        for (int i = 9; i >= 0; i--) begin
            if (pend_dn_q[i]) begin
                down_valid_d = 1'b1;
                down_idx_d   = 4'(i);
                dn_clr       = 10'd1 << i;
            end
        end

        // A new edge in the same cycle as emission keeps the bit set.
        pend_up_d = (pend_up_q & ~up_clr) | sw_rise;
        pend_dn_d = (pend_dn_q & ~dn_clr) | sw_fall;
    end

    always_ff @(posedge CLK) begin
        if (RESET) begin
            in_meta_q    <= '0;
            in_sync_q    <= '0;
            pre_cnt_q    <= '0;
            db_cnt_q     <= '0;
            level_q      <= '0;
            btn_pulse_q  <= '0;
            pend_up_q    <= '0;
            pend_dn_q    <= '0;
            up_valid_q   <= 1'b0;
            up_idx_q     <= '0;
            down_valid_q <= 1'b0;
            down_idx_q   <= '0;
        end else begin
            in_meta_q    <= in_meta_d;
            in_sync_q    <= in_sync_d;
            pre_cnt_q    <= pre_cnt_d;
            db_cnt_q     <= db_cnt_d;
            level_q      <= level_d;
            btn_pulse_q  <= btn_pulse_d;
            pend_up_q    <= pend_up_d;
            pend_dn_q    <= pend_dn_d;
            up_valid_q   <= up_valid_d;
            up_idx_q     <= up_idx_d;
            down_valid_q <= down_valid_d;
            down_idx_q   <= down_idx_d;
        end
    end

    // ms_tick is decoded from the prescaler flop; the prescaler is 0 out of
    // reset, so the strobe is 0 there as well.
    assign ms_tick    = tick;
    assign sw_level   = level_q[9:0];
    assign btn_level  = level_q[12:10];
    assign btn_pulse  = btn_pulse_q;
    assign up_valid   = up_valid_q;
    assign up_idx     = up_idx_q;
    assign down_valid = down_valid_q;
    assign down_idx   = down_idx_q;

endmodule

// File: doc/input_conditioner.md
INPUT_CONDITIONER -- requirements
Module: input_conditioner

Interface
REQ-001 The block SHALL have parameter CLK_DIV, default 100000, meaning CLK cycles per sample tick (1 ms at 100 MHz); legal range 2..2^20.
REQ-002 The block SHALL have parameter DB_SAMPLES, default 4, meaning consecutive differing ticks needed to accept a new level; legal range 1..15.
REQ-003 The block SHALL have port CLK, input, 1 bit: the single clock; all logic on its rising edge.
REQ-004 The block SHALL have port RESET, input, 1 bit: reset, synchronous, active-high.
REQ-005 The block SHALL have port SW, input, 10 bits: raw asynchronous switch levels.
REQ-006 The block SHALL have port BTN, input, 3 bits: raw asynchronous buttons; [0] ADMIN, [1] OK, [2] BACKSPACE.
REQ-007 The block SHALL have port ms_tick, output, 1 bit: one-cycle sample-tick strobe.
REQ-008 The block SHALL have port sw_level, output, 10 bits: debounced switch levels.
REQ-009 The block SHALL have port btn_level, output, 3 bits: debounced button levels.
REQ-010 The block SHALL have port btn_pulse, output, 3 bits: one-cycle strobe per debounced button press.
REQ-011 The block SHALL have ports up_valid (1 bit) and up_idx (4 bits), outputs: one switch 0->1 event and its index.
REQ-012 The block SHALL have ports down_valid (1 bit) and down_idx (4 bits), outputs: one switch 1->0 event and its index.

Function
REQ-013 SW and BTN SHALL each pass through a two-flop synchronizer before any other use.
REQ-014 The prescaler SHALL count 0..CLK_DIV-1, wrap to 0, and drive ms_tick high for exactly the cycle in which the count equals CLK_DIV-1.
REQ-015 Each of the 13 inputs SHALL have a 4-bit counter; on a tick it increments if the synchronized value differs from the debounced level, else clears; non-tick cycles hold it.
REQ-016 When a counter increment would reach DB_SAMPLES, the debounced level SHALL toggle at that edge and the counter SHALL clear.
REQ-017 A glitch shorter than DB_SAMPLES consecutive ticks SHALL never change sw_level or btn_level.
REQ-018 btn_pulse[i] SHALL be high exactly in the first cycle btn_level[i] reads 1; release SHALL produce no pulse.
REQ-019 A rising or falling debounced edge of sw_level[i] SHALL set pending_up[i] or pending_down[i] respectively.
REQ-020 Each cycle, if any pending_up bit is set, the block SHALL register up_valid=1 and up_idx set to the lowest set index, and clear that bit; otherwise up_valid=0 and up_idx=0.
REQ-021 The down path SHALL behave identically and independently of the up path, so both may be valid in the same cycle.
REQ-022 If a pending bit is cleared by emission in the same cycle a new edge sets it, set SHALL win.
REQ-023 An up and a down event of the same switch SHALL be reported separately, never merged or cancelled.
REQ-024 Event latency SHALL be one cycle from the sw_level change to the valid output when no lower-index event is pending.

Reset
REQ-025 While RESET is high at a clock edge, all synchronizers, counters, pending bits, the prescaler and every output SHALL become 0 at that edge.
REQ-026 Reset mid-operation SHALL discard pending events without emitting them.
REQ-027 After reset is released, SW or BTN inputs already high SHALL be debounced as ordinary rising edges and generate events and pulses.

Configuration
REQ-028 When macro INPUT_COND_FAST_SIM_EN is defined, the tick period SHALL be 4 cycles regardless of CLK_DIV.
REQ-029 When INPUT_COND_FAST_SIM_EN is undefined, the tick period SHALL be CLK_DIV cycles.
REQ-030 All other behaviour SHALL be identical whether or not INPUT_COND_FAST_SIM_EN is defined.

Verification
REQ-031 The bench SHALL cover: CLK_DIV=10, DB_SAMPLES=4, BTN[1] held high 60 cycles -> exactly one btn_pulse[1] cycle, btn_level[1]=1 after the 4th differing tick.
REQ-032 The bench SHALL cover: SW[3] high for 2 ticks then low -> sw_level stays 0, no up_valid.
REQ-033 The bench SHALL cover: SW[7] and SW[2] raised in the same cycle and held -> up_valid on two consecutive cycles, up_idx 2 then 7.
REQ-034 The bench SHALL cover: SW[5] debounced high, then low -> up_idx=5 event, later down_idx=5 event, up_valid=0 at the down event.
REQ-035 The bench SHALL cover: RESET asserted while up events for SW[1] and SW[4] are pending -> no further up_valid, all outputs 0 the next cycle.
REQ-036 The bench SHALL cover: INPUT_COND_FAST_SIM_EN defined with CLK_DIV=100000 -> ms_tick every 4 cycles.
